vram_writer: RTL and testbench

- Bus-snooping write path that feeds the framebuffer's VRAM write port (addr/dataIn/wr) consumed by the video scan-out block.
- Watches 68000 CPU write cycles and captures those falling inside the 16K-word screen window starting at screenBase.
- Buffers captured writes in a small FIFO.
- Replays them to the VRAM port with the timing the video block's rising-edge write detector requires: wr held 2 cycles, then at least 1 idle cycle.

---
 rtl/vram_writer_if.sv | 19 +
 rtl/vram_writer.sv | 118 +++++++++++
 tb/tb_vram_writer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_writer_if.sv
// VRAM write port bundle driven by vram_writer and
// consumed by the video scan-out block.
interface vram_writer_if;
  logic [14:0] addr;
  logic [15:0] dataOut;
  logic [1:0]  wr;

  modport master (
    output addr,
    output dataOut,
    output wr
  );

  modport slave (
    input addr,
    input dataOut,
    input wr
  );
endinterface

// File: rtl/vram_writer.sv
// Snoops 68000 writes into the screen window, queues them,
// and replays each as a 2-cycle wr strobe plus 1 idle cycle.
module vram_writer #(
  parameter int DEPTH     = 4,
  parameter int WIN_WORDS = 16384
) (
  input  logic          clk,
  input  logic          _reset,
  input  logic [20:0]   cpuAddr,
  input  logic [15:0]   cpuDataOut,
  input  logic          _cpuAS,
  input  logic          _cpuUDS,
  input  logic          _cpuLDS,
  input  logic          _cpuRW,
  input  logic [20:0]   screenBase,
  vram_writer_if.master vram,
  output logic          busy,
  output logic          overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    S1,
    S2,
    GAP
  } state_t;

  state_t state, state_n;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_n;
  logic [20:0]   off;
  logic          armed;
  logic          wcyc, in_win, cap;
  logic          full, push, pop;

  // Unsigned wrap makes addresses below screenBase land far out of range.
  assign off    = cpuAddr - screenBase;
  assign in_win = off < 21'(WIN_WORDS);
  assign wcyc   = armed & ~_cpuAS & ~_cpuRW
                & ~(_cpuUDS & _cpuLDS);
  assign cap    = wcyc & in_win;
  assign full   = count == CW'(DEPTH);
  assign push   = cap & ~full;

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      IDLE, GAP: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_n = S1;
        end else begin
          state_n = IDLE;
        end
      end
      S1:      state_n = S2;
      S2:      state_n = GAP;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    count_n = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!_reset) begin
      state        <= IDLE;
      count        <= '0;
      wptr         <= '0;
      rptr         <= '0;
      armed        <= 1'b0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
      vram.addr    <= '0;
      vram.dataOut <= '0;
      vram.wr      <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      busy  <= (count_n != '0) | (state_n != IDLE);
      if (_cpuAS) begin
        armed <= 1'b1;
      end else if (wcyc) begin
        armed <= 1'b0;
      end
      if (cap & full) begin
        overflow <= 1'b1;
      end
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr         <= rptr + AW'(1);
        vram.addr    <= {1'b0, mem[rptr][31:18]};
        vram.dataOut <= mem[rptr][17:2];
        vram.wr      <= mem[rptr][1:0];
      end else if (state == S2) begin
        vram.wr <= '0;
      end
    end
  end

  // Entry layout: {offset[13:0], data, upper_en, lower_en}.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {off[13:0], cpuDataOut,
                    ~_cpuUDS, ~_cpuLDS};
    end
  end

endmodule

// File: tb/tb_vram_writer.sv
// Randomised scoreboard bench for vram_writer with an
// edge-indexed reference model of capture, queueing and replay.
module tb_vram_writer;
  localparam int DEPTH = 4;
  localparam int WIN   = 16384;

  logic        clk = 1'b0;
  logic        _reset;
  logic [20:0] cpuAddr, screenBase;
  logic [15:0] cpuDataOut;
  logic        _cpuAS, _cpuUDS, _cpuLDS, _cpuRW;
  logic        busy, overflow;

  always #5 clk = ~clk;

  vram_writer_if vif ();

  vram_writer #(
    .DEPTH(DEPTH),
    .WIN_WORDS(WIN)
  ) dut (
    .clk(clk),
    ._reset(_reset),
    .cpuAddr(cpuAddr),
    .cpuDataOut(cpuDataOut),
    ._cpuAS(_cpuAS),
    ._cpuUDS(_cpuUDS),
    ._cpuLDS(_cpuLDS),
    ._cpuRW(_cpuRW),
    .screenBase(screenBase),
    .vram(vif),
    .busy(busy),
    .overflow(overflow)
  );

  typedef struct {
    int          pop;
    logic [14:0] addr;
    logic [15:0] data;
    logic [1:0]  en;
  } exp_t;

  exp_t sb[$];
  int   pend[$];
  int   cyc      = 0;
  int   last_pop = -100;
  bit   m_armed  = 1'b0;
  bit   exp_ovf  = 1'b0;
  int   errors   = 0;
  int   checks   = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: each accepted write gets the edge at which it
  // leaves the queue; replay slots are spaced 3 edges apart.
  always @(posedge clk) begin : model
    logic [20:0] off;
    int          p;
    exp_t        e;
    if (!_reset) begin
      m_armed  = 1'b0;
      exp_ovf  = 1'b0;
      last_pop = -100;
      sb.delete();
      pend.delete();
    end else if (_cpuAS) begin
      m_armed = 1'b1;
    end else if (m_armed && !_cpuRW && !(_cpuUDS && _cpuLDS)) begin
      m_armed = 1'b0;
      off     = cpuAddr - screenBase;
      if (int'(off) < WIN) begin
        while (pend.size() > 0 && pend[0] < cyc) void'(pend.pop_front());
        if (pend.size() == DEPTH) begin
          exp_ovf = 1'b1;
        end else begin
          p        = (cyc + 1 > last_pop + 3) ? cyc + 1 : last_pop + 3;
          last_pop = p;
          pend.push_back(p);
          e.pop  = p;
          e.addr = {1'b0, off[13:0]};
          e.data = cpuDataOut;
          e.en   = {~_cpuUDS, ~_cpuLDS};
          sb.push_back(e);
        end
      end
    end
    cyc++;
  end

  int          run = 0;
  exp_t        cur;
  logic [14:0] h_addr;
  logic [15:0] h_data;

  always @(negedge clk) begin : monitor
    if (!_reset) begin
      run = 0;
    end else if (vif.wr != 2'b00) begin
      if (run == 0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h wr %b expected none",
                   vif.addr, vif.dataOut, vif.wr);
        end else begin
          cur = sb.pop_front();
          chk("addr", 32'(vif.addr), 32'(cur.addr));
          chk("data", 32'(vif.dataOut), 32'(cur.data));
          chk("wr_en", 32'(vif.wr), 32'(cur.en));
          chk("latency", 32'(cyc), 32'(cur.pop + 1));
        end
        h_addr = vif.addr;
        h_data = vif.dataOut;
        run    = 1;
      end else begin
        run++;
        chk("strobe_addr_hold", 32'(vif.addr), 32'(h_addr));
      end
    end else if (run > 0) begin
      chk("strobe_len", 32'(run), 32'd2);
      chk("gap_addr_hold", 32'(vif.addr), 32'(h_addr));
      chk("gap_data_hold", 32'(vif.dataOut), 32'(h_data));
      run = 0;
    end
  end

  task automatic bus(input logic [20:0] a, input logic [15:0] d,
                     input logic u, input logic l,
                     input logic rw, input int n);
    cpuAddr    = a;
    cpuDataOut = d;
    _cpuUDS    = u;
    _cpuLDS    = l;
    _cpuRW     = rw;
    _cpuAS     = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    _cpuAS  = 1'b1;
    _cpuUDS = 1'b1;
    _cpuLDS = 1'b1;
    _cpuRW  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((sb.size() != 0 || vif.wr != 2'b00 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(name, 32'(sb.size()), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t;
    int          s;
    logic [20:0] a;
    _reset     = 1'b0;
    _cpuAS     = 1'b1;
    _cpuUDS    = 1'b1;
    _cpuLDS    = 1'b1;
    _cpuRW     = 1'b1;
    cpuAddr    = '0;
    cpuDataOut = '0;
    screenBase = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr", 32'(vif.wr), 32'd0);
    chk("rst_addr", 32'(vif.addr), 32'd0);
    chk("rst_data", 32'(vif.dataOut), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    _reset = 1'b1;
    @(posedge clk);
    #1;

    screenBase = 21'h1FD380;
    bus(21'h1FD381, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1);
    chk("busy_after_capture", 32'(busy), 32'd1);
    drain("drain_single");

    bus(21'h1FD380, 16'h12FF, 1'b1, 1'b0, 1'b0, 1);
    bus(21'h1FD380, 16'h34AB, 1'b0, 1'b1, 1'b0, 1);
    drain("drain_bytes");

    screenBase = 21'h100000;
    bus(21'h103FFF, 16'h1111, 1'b0, 1'b0, 1'b0, 1);
    bus(21'h104000, 16'h2222, 1'b0, 1'b0, 1'b0, 1);
    bus(21'h0FFFFF, 16'h3333, 1'b0, 1'b0, 1'b0, 1);
    bus(21'h100000, 16'h4444, 1'b0, 1'b0, 1'b1, 1);
    drain("drain_window");

    bus(21'h100010, 16'h5A5A, 1'b0, 1'b0, 1'b0, 10);
    drain("drain_held");

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) screenBase = 21'($urandom);
      a = 21'(screenBase + 21'($urandom_range(0, WIN + 199)) - 21'd100);
      s = $urandom_range(0, 6);
      bus(a, 16'($urandom),
          (s == 1 || s == 6) ? 1'b1 : 1'b0,
          (s == 2 || s == 6) ? 1'b1 : 1'b0,
          ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
          $urandom_range(1, 3));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain("drain_random");
    chk("ovf_random", 32'(overflow), 32'(exp_ovf));

    screenBase = 21'h100000;
    for (int i = 0; i < 14; i++) begin
      bus(21'(21'h100000 + 21'(i)), 16'(16'hB000 + i),
          1'b0, 1'b0, 1'b0, 1);
    end
    @(negedge clk);
    chk("ovf_burst", 32'(overflow), 32'd1);

    t = 0;
    @(negedge clk);
    while (vif.wr == 2'b00 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL wait_strobe: got no strobe expected strobe");
    end
    #1;
    _reset     = 1'b0;
    _cpuAS     = 1'b0;
    _cpuRW     = 1'b0;
    _cpuUDS    = 1'b0;
    _cpuLDS    = 1'b0;
    cpuAddr    = 21'h100005;
    cpuDataOut = 16'hDEAD;
    @(negedge clk);
    chk("midrst_wr", 32'(vif.wr), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    _reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("no_capture_after_rst", 32'(busy), 32'd0);
    _cpuAS  = 1'b1;
    _cpuUDS = 1'b1;
    _cpuLDS = 1'b1;
    _cpuRW  = 1'b1;
    @(posedge clk);
    #1;
    bus(21'h100007, 16'h7777, 1'b0, 1'b0, 1'b0, 1);
    drain("drain_after_rst");
    chk("ovf_final", 32'(overflow), 32'(exp_ovf));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
